imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the decode-side immediate extraction. Takes a 32-bit immediate, an immediate-type code and a template instruction word (opcode/rd/rs1/rs2/funct fields), range-checks the immediate, and scatters its bits into RV32I instruction positions.
- Streams the encoded words with sequential addresses to an instruction-memory write port.
- Used by the boot/program loader and by the test harness to build instruction images in hardware.

Parameters:
- ADDR_W, 12, width of out_addr (byte address).
- BASE_ADDR, 0, address of first word written after start.
- LEN_W, 10, width of the len input (max instructions per run).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run (ignored unless IDLE).
- len  in  LEN_W  number of input items in the run, sampled on start; 0 means go straight to DONE.
- in_valid  in  1  input item valid.
- in_ready  out  1  input item accepted when in_valid && in_ready.
- in_imm  in  32  immediate value (already sign-extended / byte-offset form).
- in_imm_type  in  3  000 I, 001 B, 010 S, 011 U, 100 J, 101 shamt; 110/111 invalid.
- in_tmpl  in  32  template instruction; bits at immediate positions are overwritten.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  sink accepts when out_valid && out_ready.
- out_addr  out  ADDR_W  byte address of out_instr.
- out_instr  out  32  encoded instruction.
- err  out  1  sticky; set on any rejected item, cleared by start.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset: FSM=IDLE; in_ready, out_valid, err, done = 0; out_addr = BASE_ADDR; out_instr = 0; item counter = 0.
- FSM states:
  - IDLE: in_ready=0. On start: latch len, clear err, out_addr=BASE_ADDR. Next state RUN, or DONE if len==0.
  - RUN: in_ready = !out_valid || out_ready. Each accept increments the item counter. On the accept making counter==len, next state DRAIN.
  - DRAIN: in_ready=0. Wait until out_valid==0, or its handshake completes this cycle, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Datapath: single output register.
  - Accepted valid item -> out_valid=1 next cycle (latency 1). out_instr and out_addr hold stable while out_valid && !out_ready.
  - Simultaneous out handshake and new accept: the register reloads the same cycle with no bubble.
- Addressing: out_addr increments by 4 on each out handshake. The first word goes to BASE_ADDR. Wraps modulo 2^ADDR_W with no flag.
- Range rules (item rejected if violated):
  - I and S: in_imm[31:11] all equal.
  - B: in_imm[0]==0 and in_imm[31:12] all equal.
  - J: in_imm[0]==0 and in_imm[31:20] all equal.
  - U: in_imm[11:0]==0.
  - shamt: in_imm[31:5]==0.
  - Types 110/111 always rejected.
- Rejected item: still handshaken and counted toward len; no output word, out_addr unchanged; err set.
- Encoding (unlisted bits taken from in_tmpl):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - shamt: [24:20]=imm[4:0]; [31:25] keep the template funct7.
- start while not IDLE: ignored.
- Asynchronous reset mid-run: pending output discarded, FSM returns to IDLE immediately.

Optional Feature:
- Macro IMM_ENCODER_ERR_COUNT_EN.
- Defined: adds output port err_count (8 bits).
  - Reset 0; cleared on start.
  - Increments per rejected item and saturates at 255.
  - err remains present.
- Undefined: no err_count port and no counter logic.

Test Plan:
- start len=1; I, tmpl 0x00000093, imm 0xFFFFFFFF -> out_instr 0xFFF00093 at addr 0x000, then done pulse.
- len=3: B tmpl 0x00000063 imm 8; J tmpl 0x0000006F imm 0xFFFFFFFC; U tmpl 0x000002B7 imm 0x12345000 -> 0x00000463 @0x000, 0xFFDFF06F @0x004, 0x123452B7 @0x008.
- len=2: I imm 0x00000800, then shamt tmpl 0x40005013 imm 3 -> first item rejected, err=1; single output 0x40305013 at addr 0x000; done after.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr stable; on release, back-to-back transfers with no bubble.
- rst_n low mid-run with out_valid=1 -> out_valid, in_ready, err = 0 immediately; a following start begins at BASE_ADDR.
- With IMM_ENCODER_ERR_COUNT_EN: 300 items of type 111 -> err_count saturates at 255; next start clears it to 0.

Source files
------------

// File: rtl/imm_encoder.sv
// RV32I immediate encoder: range-checks an immediate and scatters it into a template word, streaming results to an imem write port.
// Optional build macro IMM_ENCODER_ERR_COUNT_EN adds an 8-bit saturating rejected-item counter port (err_count).
module imm_encoder #(
  parameter int          ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          LEN_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_imm,
  input  logic [2:0]        in_imm_type,
  input  logic [31:0]       in_tmpl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic              err,
  output logic              done
`ifdef IMM_ENCODER_ERR_COUNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] T_I     = 3'b000;
  localparam logic [2:0] T_B     = 3'b001;
  localparam logic [2:0] T_S     = 3'b010;
  localparam logic [2:0] T_U     = 3'b011;
  localparam logic [2:0] T_J     = 3'b100;
  localparam logic [2:0] T_SHAMT = 3'b101;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  state_t              r_state;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_count;
  logic                r_out_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_instr;
  logic                r_err;
  logic                r_done;
`ifdef IMM_ENCODER_ERR_COUNT_EN
  logic [7:0]          r_err_count;
`endif

  logic                w_in_ready;
  logic                w_accept;
  logic                w_out_hs;
  logic [LEN_W-1:0]    w_count_inc;
  logic                w_ok;
  logic [31:0]         w_enc;
  logic                w_fit12;
  logic                w_fit13;
  logic                w_fit21;

  // Sign-extension checks: the upper bits must all be copies of the top kept bit.
  assign w_fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    w_ok  = 1'b0;
    w_enc = in_tmpl;
    case (in_imm_type)
      T_I: begin
        w_ok         = w_fit12;
        w_enc[31:20] = in_imm[11:0];
      end
      T_S: begin
        w_ok         = w_fit12;
        w_enc[31:25] = in_imm[11:5];
        w_enc[11:7]  = in_imm[4:0];
      end
      T_B: begin
        w_ok         = w_fit13 && !in_imm[0];
        w_enc[31]    = in_imm[12];
        w_enc[30:25] = in_imm[10:5];
        w_enc[11:8]  = in_imm[4:1];
        w_enc[7]     = in_imm[11];
      end
      T_U: begin
        w_ok         = ~(|in_imm[11:0]);
        w_enc[31:12] = in_imm[31:12];
      end
      T_J: begin
        w_ok         = w_fit21 && !in_imm[0];
        w_enc[31]    = in_imm[20];
        w_enc[30:21] = in_imm[10:1];
        w_enc[20]    = in_imm[11];
        w_enc[19:12] = in_imm[19:12];
      end
      T_SHAMT: begin
        w_ok         = ~(|in_imm[31:5]);
        w_enc[24:20] = in_imm[4:0];
      end
      default: begin
        w_ok  = 1'b0;
        w_enc = in_tmpl;
      end
    endcase
  end

  assign w_in_ready  = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_count_inc = r_count + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_addr      <= BASE;
      r_instr     <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
`ifdef IMM_ENCODER_ERR_COUNT_EN
      r_err_count <= '0;
`endif
    end else begin
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_addr      <= r_addr + STEP;
      end

      // A new accept overrides the clear above, so a draining and a loading word share one cycle.
      if (w_accept) begin
        r_count <= w_count_inc;
        if (w_ok) begin
          r_out_valid <= 1'b1;
          r_instr     <= w_enc;
        end else begin
          r_err <= 1'b1;
`ifdef IMM_ENCODER_ERR_COUNT_EN
          if (r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
          end
`endif
        end
      end

      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_len   <= len;
            r_count <= '0;
            r_err   <= 1'b0;
            r_addr  <= BASE;
`ifdef IMM_ENCODER_ERR_COUNT_EN
            r_err_count <= '0;
`endif
            if (len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_accept && (w_count_inc == r_len)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_out_valid || w_out_hs) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_addr  = r_addr;
  assign out_instr = r_instr;
  assign err       = r_err;
  assign done      = r_done;
`ifdef IMM_ENCODER_ERR_COUNT_EN
  assign err_count = r_err_count;
`endif

endmodule
